// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, CTRL/STATUS
// bit positions and the state encoding used by both the TX and RX machines.
package uart_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_TXDATA = 2'd3;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_OVERRUN = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_FRAME_ERR  = 3;

    localparam int CTRL_CLR_OVERRUN = 1;
    localparam int CTRL_CLR_FRAME   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign full      = (count_r == CNT_DEPTH);
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// 8N1 UART behind a 4-byte register window: CTRL, RXDATA, STATUS, TXDATA.
// TX has no buffer; RX bytes land in a small FIFO with sticky error flags.
module uart_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0038_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          RX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        mem_reset,
    input  logic [31:0] address,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        sel,
    input  logic        rx,
    output logic        tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [31:0]      offset_s;
    logic [1:0]       reg_off_s;
    logic             sel_s;
    logic             ctrl_wr_s;
    logic             tx_wr_s;
    logic             pop_s;
    logic [3:0]       status_s;
    logic             wdata_unused_s;

    uart_state_e      tx_state_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [2:0]       tx_idx_r;
    logic [7:0]       tx_shift_r;
    logic             tx_r;
    logic             tx_busy_r;

    logic [1:0]       rx_sync_r;
    logic             rx_prev_r;
    logic             rx_s;
    uart_state_e      rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_idx_r;
    logic [7:0]       rx_shift_r;
    logic             rx_stop_smp_s;
    logic             rx_good_s;
    logic             push_s;
    logic             overrun_set_s;
    logic             frame_set_s;
    logic             rx_overrun_r;
    logic             frame_err_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_head_s;

    // A 32-bit subtract keeps the decode exact for any base, aligned or not.
    assign offset_s       = address - BASE_ADDR;
    assign sel_s          = (offset_s < 32'd4);
    assign reg_off_s      = offset_s[1:0];
    assign sel            = sel_s;
    assign ctrl_wr_s      = sel_s && write_en && (reg_off_s == OFF_CTRL);
    assign tx_wr_s        = sel_s && write_en && (reg_off_s == OFF_TXDATA);
    assign pop_s          = sel_s && read_en && (reg_off_s == OFF_RXDATA) && !fifo_empty_s;
    assign wdata_unused_s = ^write_data[31:8];
    assign tx             = tx_r;
    assign rx_s           = rx_sync_r[1];

    assign rx_stop_smp_s = (rx_state_r == S_STOP) && (rx_cnt_r == BIT_LAST);
    assign rx_good_s     = rx_stop_smp_s && rx_s;
    assign frame_set_s   = rx_stop_smp_s && !rx_s;
    assign push_s        = rx_good_s && (!fifo_full_s || pop_s);
    assign overrun_set_s = rx_good_s && fifo_full_s && !pop_s;

    // STATUS word assembly.
    always_comb begin
        status_s                = 4'd0;
        status_s[ST_TX_BUSY]    = tx_busy_r;
        status_s[ST_RX_OVERRUN] = rx_overrun_r;
        status_s[ST_RX_VALID]   = !fifo_empty_s;
        status_s[ST_FRAME_ERR]  = frame_err_r;
    end

    // Load data mux; write-only offsets and misses read as zero.
    always_comb begin
        read_data = 32'd0;
        if (sel_s) begin
            case (reg_off_s)
                OFF_RXDATA: read_data = fifo_empty_s ? 32'd0 : {24'd0, fifo_head_s};
                OFF_STATUS: read_data = {28'd0, status_s};
                default:    read_data = 32'd0;
            endcase
        end else begin
            read_data = 32'd0;
        end
    end

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (mem_reset) begin
            rx_sync_r <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx};
            rx_prev_r <= rx_s;
        end
    end

    // TX machine: tx_busy mirrors "not idle" and is set on the accepting edge.
    always_ff @(posedge clk) begin
        if (mem_reset) begin
            tx_state_r <= S_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            case (tx_state_r)
                S_IDLE: begin
                    tx_cnt_r <= CNT_ZERO;
                    tx_idx_r <= 3'd0;
                    if (tx_wr_s) begin
                        tx_shift_r <= write_data[7:0];
                        tx_r       <= 1'b0;
                        tx_busy_r  <= 1'b1;
                        tx_state_r <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_r       <= tx_shift_r[0];
                        tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                        tx_state_r <= S_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= CNT_ZERO;
                        if (tx_idx_r == 3'd7) begin
                            tx_r       <= 1'b1;
                            tx_state_r <= S_STOP;
                        end else begin
                            tx_r       <= tx_shift_r[0];
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_idx_r   <= tx_idx_r + 3'd1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_busy_r  <= 1'b0;
                        tx_state_r <= S_IDLE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_state_r <= S_IDLE;
                    tx_r       <= 1'b1;
                    tx_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // RX machine: mid-start check rejects glitches, then one sample per bit period.
    always_ff @(posedge clk) begin
        if (mem_reset) begin
            rx_state_r <= S_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_idx_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            case (rx_state_r)
                S_IDLE: begin
                    rx_cnt_r <= CNT_ZERO;
                    rx_idx_r <= 3'd0;
                    if (rx_prev_r && !rx_s) begin
                        rx_state_r <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_state_r <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_shift_r <= {rx_s, rx_shift_r[7:1]};
                        if (rx_idx_r == 3'd7) begin
                            rx_state_r <= S_STOP;
                        end else begin
                            rx_idx_r <= rx_idx_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_state_r <= S_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                default: rx_state_r <= S_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (mem_reset) begin
            rx_overrun_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_overrun_r <= overrun_set_s |
                            (rx_overrun_r & ~(ctrl_wr_s & write_data[CTRL_CLR_OVERRUN]));
            frame_err_r  <= frame_set_s |
                            (frame_err_r & ~(ctrl_wr_s & write_data[CTRL_CLR_FRAME]));
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (mem_reset),
        .push      (push_s),
        .push_data (rx_shift_r),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: a queue-based model of the register map, the
// RX FIFO and the TX line predicts every load result and every transmitted frame.
module tb_uart_mmio;
    localparam logic [31:0] BASE  = 32'h0038_0000;
    localparam int          CPB   = 16;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk        = 1'b0;
    logic        mem_reset  = 1'b1;
    logic [31:0] address    = 32'h0;
    logic        write_en   = 1'b0;
    logic        read_en    = 1'b0;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        sel;
    logic        rx         = 1'b1;
    logic        tx;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    // reference model state
    logic [7:0]  m_fifo[$];
    bit          m_overrun   = 1'b0;
    bit          m_frame_err = 1'b0;
    int          tx_start_edge = -100000;

    // scoreboard queues
    logic [7:0]  exp_tx[$];
    int          exp_tx_edge[$];
    logic [31:0] exp_rd_data[$];
    logic        exp_rd_sel[$];
    logic [31:0] exp_rd_addr[$];

    // TX monitor state
    bit          mon_active = 1'b0;
    int          mon_k      = 0;
    int          mon_bad    = 0;
    logic [7:0]  mon_byte   = 8'h0;
    logic [9:0]  mon_frame  = 10'h3FF;
    logic        tx_prev    = 1'b1;

    uart_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .RX_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .mem_reset  (mem_reset),
        .address    (address),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_data (write_data),
        .read_data  (read_data),
        .sel        (sel),
        .rx         (rx),
        .tx         (tx)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    function automatic bit m_busy(input int e);
        return (e >= tx_start_edge) && (e < tx_start_edge + FRAME);
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        write_en   = 1'b0;
        read_en    = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic issue_read(input logic [31:0] addr);
        logic [31:0] off;
        logic [31:0] exp;
        logic        valid;
        logic        busy;
        off   = addr - BASE;
        exp   = 32'h0;
        valid = (m_fifo.size() > 0);
        busy  = m_busy(edge_cnt);
        if (off == 32'd1 && valid) begin
            exp = {24'h0, m_fifo.pop_front()};
        end else if (off == 32'd2) begin
            exp = {28'h0, m_frame_err, valid, m_overrun, busy};
        end
        exp_rd_data.push_back(exp);
        exp_rd_sel.push_back(off < 32'd4);
        exp_rd_addr.push_back(addr);
        address = addr;
        read_en = 1'b1;
    endtask

    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        off = addr - BASE;
        if (off == 32'd0) begin
            if (data[1]) m_overrun = 1'b0;
            if (data[3]) m_frame_err = 1'b0;
        end else if (off == 32'd3 && !m_busy(edge_cnt)) begin
            tx_start_edge = edge_cnt + 1;
            exp_tx.push_back(data[7:0]);
            exp_tx_edge.push_back(edge_cnt + 1);
        end
        address    = addr;
        write_data = data;
        write_en   = 1'b1;
    endtask

    task automatic rd(input logic [31:0] addr);
        next_cycle();
        issue_read(addr);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        next_cycle();
        issue_write(addr, data);
    endtask

    // Serialize one 8N1 frame on rx; optionally issue an RXDATA load at cycle pop_at.
    task automatic send_rx(input logic [7:0] b, input bit good, input int pop_at);
        logic [9:0] frame;
        frame = {good, b, 1'b0};
        for (int j = 0; j < FRAME; j++) begin
            next_cycle();
            rx = frame[j / CPB];
            if (j == pop_at) issue_read(BASE + 32'd1);
        end
        next_cycle();
        rx = 1'b1;
        if (!good) m_frame_err = 1'b1;
        else if (m_fifo.size() < DEPTH) m_fifo.push_back(b);
        else m_overrun = 1'b1;
        idle(4);
    endtask

    task automatic glitch();
        next_cycle();
        rx = 1'b0;
        idle(2);
        next_cycle();
        rx = 1'b1;
        idle(20);
    endtask

    // Reset with a concurrent TXDATA store, which must not start a frame.
    task automatic pulse_reset();
        next_cycle();
        mem_reset  = 1'b1;
        address    = BASE + 32'd3;
        write_data = 32'hFF;
        write_en   = 1'b1;
        m_fifo.delete();
        m_overrun     = 1'b0;
        m_frame_err   = 1'b0;
        tx_start_edge = -100000;
        exp_tx.delete();
        exp_tx_edge.delete();
        next_cycle();
        mem_reset = 1'b0;
        @(negedge clk);
        check_bit("tx_after_reset", tx, 1'b1);
    endtask

    // Load monitor: every read strobe is compared against the predicted value.
    initial forever begin
        logic [31:0] e_data;
        logic        e_sel;
        logic [31:0] e_addr;
        @(negedge clk);
        if (read_en === 1'b1) begin
            checks++;
            if (exp_rd_data.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: load at %h with no prediction", address);
            end else begin
                e_data = exp_rd_data.pop_front();
                e_sel  = exp_rd_sel.pop_front();
                e_addr = exp_rd_addr.pop_front();
                if (read_data !== e_data || sel !== e_sel) begin
                    failures++;
                    $display("FAIL rd_%h: got data=%h sel=%b, required data=%h sel=%b",
                             e_addr, read_data, sel, e_data, e_sel);
                end
            end
        end
    end

    // TX monitor: detects a start bit, checks its timing, then every cycle of the frame.
    initial forever begin
        int e_edge;
        @(negedge clk);
        if (mem_reset === 1'b1) begin
            mon_active = 1'b0;
        end else if (mon_active) begin
            if (tx !== mon_frame[mon_k / CPB]) mon_bad++;
            mon_k++;
            if (mon_k == FRAME) begin
                checks++;
                if (mon_bad != 0) begin
                    failures++;
                    $display("FAIL tx_frame: byte %h had %0d wrong tx cycles, required 0",
                             mon_byte, mon_bad);
                end
                mon_active = 1'b0;
            end
        end else if (tx === 1'b0 && tx_prev === 1'b1) begin
            checks++;
            if (exp_tx.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected: start bit at edge %0d, required none", edge_cnt);
            end else begin
                mon_byte = exp_tx.pop_front();
                e_edge   = exp_tx_edge.pop_front();
                if (e_edge != edge_cnt) begin
                    failures++;
                    $display("FAIL tx_start_time: start at edge %0d, required %0d", edge_cnt, e_edge);
                end
                mon_frame  = {1'b1, mon_byte, 1'b0};
                mon_active = 1'b1;
                mon_k      = 1;
                mon_bad    = 0;
            end
        end
        tx_prev = tx;
    end

    initial begin
        int act;
        idle(3);
        mem_reset = 1'b0;
        @(negedge clk);
        check_bit("tx_reset_idle", tx, 1'b1);
        rd(BASE + 32'd2);
        rd(BASE + 32'd1);
        rd(BASE + 32'd0);
        rd(BASE + 32'd3);
        rd(BASE + 32'd4);
        rd(BASE - 32'd1);
        rd(BASE ^ 32'h4000_0000);

        // 0x55 frame with a STATUS load every cycle across the busy boundary
        wr(BASE + 32'd3, 32'h55);
        for (int i = 0; i < FRAME + 6; i++) begin
            if (i == 40) wr(BASE + 32'd3, 32'hAA);
            else rd(BASE + 32'd2);
        end

        send_rx(8'hA3, 1'b1, -1);
        rd(BASE + 32'd2);
        rd(BASE + 32'd1);
        rd(BASE + 32'd2);
        rd(BASE + 32'd1);

        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, -1);
        rd(BASE + 32'd2);
        repeat (5) rd(BASE + 32'd1);
        wr(BASE + 32'd0, 32'h2);
        rd(BASE + 32'd2);

        send_rx(8'h7E, 1'b0, -1);
        rd(BASE + 32'd2);
        rd(BASE + 32'd1);
        wr(BASE + 32'd0, 32'h8);
        rd(BASE + 32'd2);

        glitch();
        rd(BASE + 32'd2);
        send_rx(8'h5A, 1'b1, -1);
        rd(BASE + 32'd1);

        // full FIFO: pop lands on the same edge as the fifth push
        for (int i = 0; i < DEPTH; i++) send_rx(8'hC0 + 8'(i), 1'b1, -1);
        send_rx(8'hD5, 1'b1, 154);
        rd(BASE + 32'd2);
        repeat (5) rd(BASE + 32'd1);

        // reset during data bit 3, then a clean frame
        wr(BASE + 32'd3, 32'h3C);
        idle(4 * CPB + 6);
        pulse_reset();
        rd(BASE + 32'd2);
        wr(BASE + 32'd3, 32'h96);
        idle(FRAME + 4);
        rd(BASE + 32'd2);

        for (int it = 0; it < 80; it++) begin
            act = int'($urandom_range(0, 9));
            case (act)
                0, 1:    send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
                                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 140)) : -1);
                2, 3:    rd(BASE + 32'd1);
                4:       rd(BASE + 32'd2);
                5:       rd(BASE + 32'($urandom_range(0, 7)));
                6:       wr(BASE + 32'd0, $urandom());
                7:       wr(BASE + 32'd3, $urandom());
                8:       glitch();
                default: idle(int'($urandom_range(0, 30)));
            endcase
        end

        idle(FRAME + 20);
        rd(BASE + 32'd2);
        next_cycle();
        checks++;
        if (exp_tx.size() != 0 || exp_rd_data.size() != 0 || mon_active) begin
            failures++;
            $display("FAIL drain: %0d tx frames and %0d loads still pending, required 0",
                     exp_tx.size(), exp_rd_data.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0038_0000: byte base address of the register window (offsets 0..3).
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200).
REQ-003 Parameter RX_DEPTH, default 4: RX FIFO entries, power of two, at least 2.
REQ-004 Port clk  input  1: single clock, all logic on posedge.
REQ-005 Port mem_reset  input  1: synchronous, active-high reset.
REQ-006 Port address  input  32: byte address from the CPU data bus.
REQ-007 Port write_en  input  1: write strobe, one cycle per store.
REQ-008 Port read_en  input  1: read strobe, one cycle per load; the only trigger for read side effects.
REQ-009 Port write_data  input  32: store data; only bits [7:0] are used.
REQ-010 Port read_data  output  32: load data, combinational from address.
REQ-011 Port sel  output  1: high when address lies in BASE_ADDR..BASE_ADDR+3.
REQ-012 Port rx  input  1: asynchronous serial input, idle high.
REQ-013 Port tx  output  1: serial output, idle high.

Function
REQ-014 Register map by offset: 0 CTRL (write), 1 RXDATA (read), 2 STATUS (read), 3 TXDATA (write).
REQ-015 STATUS bits: [0] tx_busy, [1] rx_overrun (sticky), [2] rx_valid (FIFO not empty), [3] frame_err (sticky), [31:4] zero.
REQ-016 read_data for a selected offset is the register zero-extended to 32 bits; unselected addresses and write-only offsets return 0.
REQ-017 RXDATA read returns the FIFO head; read_en with offset 1 and FIFO not empty pops one entry at the clock edge.
REQ-018 RXDATA read with an empty FIFO returns 0 and leaves the FIFO unchanged.
REQ-019 CTRL write: bit1=1 clears rx_overrun; bit3=1 clears frame_err; other bits are ignored.
REQ-020 TXDATA write while tx_busy=0 starts a frame on the next cycle and sets tx_busy in that cycle.
REQ-021 TXDATA write while tx_busy=1 is dropped silently; there is no TX buffer.
REQ-022 TX FSM states: IDLE, START, DATA, STOP.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Data is sent LSB first, 8N1.
  - tx_busy clears on the cycle the FSM returns to IDLE.
REQ-023 rx passes through a two-flop synchronizer before use.
REQ-024 RX FSM states: IDLE, START, DATA, STOP.
  - IDLE to START on a synchronized falling edge.
  - START samples at CLKS_PER_BIT/2; a high sample returns to IDLE (glitch reject).
  - Data bits are sampled every CLKS_PER_BIT from mid-start.
REQ-025 Stop-bit sample low: the byte is discarded and frame_err is set; the FSM still returns to IDLE.
REQ-026 Valid byte with FIFO full: the byte is discarded and rx_overrun is set; FIFO contents are unchanged.
REQ-027 Simultaneous push and pop in one cycle, including when full, are both honoured; count is unchanged.
REQ-028 FIFO pointers wrap modulo RX_DEPTH; count width is clog2(RX_DEPTH)+1.
REQ-029 Address decode uses exact 32-bit compares; no aliasing outside the 4-byte window.

Reset
REQ-030 On mem_reset: tx=1, tx_busy=0, both FSMs in IDLE, FIFO empty, rx_overrun=0, frame_err=0, baud counters=0, synchronizer flops=1.
REQ-031 Reset asserted mid-frame aborts the frame immediately; tx is high on the cycle after the reset edge.
REQ-032 Reset has priority over write_en and read_en in the same cycle.

Structure
REQ-033 Shared package uart_pkg holds the register offset constants, STATUS bit indices and the FSM state encodings.
REQ-034 The RX FIFO is a sub-module, sync_fifo (parameters WIDTH=8, DEPTH), with push/pop/full/empty/head ports.
REQ-035 TX and RX FSMs are in uart_mmio; each has its own baud counter.

Verification (CLKS_PER_BIT=16, RX_DEPTH=4)
REQ-036 Write 0x55 to BASE+3: tx shows a start bit, then 1,0,1,0,1,0,1,0, then a stop bit, 16 clocks each; STATUS[0]=1 throughout and 0 after 160 clocks.
REQ-037 Drive byte 0xA3 on rx: STATUS reads 0x4; read BASE+1 with read_en returns 0xA3; STATUS then reads 0x0.
REQ-038 Send 5 bytes 0x01..0x05 with no reads: STATUS=0x6; the four reads return 0x01..0x04; write 0x2 to BASE+0 gives STATUS=0x0.
REQ-039 rx frame 0x7E with a low stop bit: FIFO stays empty; STATUS=0x8.
REQ-040 A 3-clock low glitch on rx: no byte received; the RX FSM is back in IDLE by clock 8.
REQ-041 mem_reset asserted during TX bit 3: tx=1 and STATUS=0 the next cycle; a new TXDATA write then transmits normally.
